// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Purpose:
//   Arbitrates instruction fetches and data loads/stores from a core onto a
//   single shared memory port with a bidirectional data bus. One access is
//   in flight at a time. Requests are accepted from IDLE with priority
//   d_write > d_read > fetch_req. An access that is not answered within
//   TIMEOUT cycles parks the controller in ERR until reset.
//
// Parameters:
//   WORD_SIZE   width of the address and data buses
//   TIMEOUT     maximum number of waiting cycles before declaring an error
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   fetch_req, pc               instruction fetch request and address
//   d_read, d_write             data load / store requests
//   d_addr, d_wdata             data address and store data
//   inst, inst_valid            last fetched instruction, one-cycle update pulse
//   d_rdata, d_done             last loaded word, one-cycle completion pulse
//   busy                        high whenever the controller is not idle
//   timeout_err                 sticky memory-timeout flag
//   num_inst                    number of completed fetches (wraps)
//   readM, writeM, address      memory strobes and address
//   data                        shared memory data bus (driven only while storing)
//   inputReady, ackOutput       memory read-data-valid / write-accepted
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic [WORD_SIZE-1:0] pc,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] inst,
    output logic                 inst_valid,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_done,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [WORD_SIZE-1:0] num_inst,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput
);

    // Wide enough to hold the value TIMEOUT itself.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IFETCH = 3'd1,
        DREAD  = 3'd2,
        DWRITE = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        wait_q;
    logic [CW-1:0]        wait_d;
    logic                 timed_out;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] address_q;
    logic [WORD_SIZE-1:0] inst_q;
    logic [WORD_SIZE-1:0] d_rdata_q;
    logic [WORD_SIZE-1:0] num_inst_q;
    logic                 readM_q;
    logic                 writeM_q;
    logic                 inst_valid_q;
    logic                 d_done_q;
    logic                 busy_q;
    logic                 timeout_err_q;

    // A cycle spent waiting that brings the count to TIMEOUT is the last one
    // allowed; a response on that same edge still wins.
    assign wait_d    = wait_q + CW'(1);
    assign timed_out = (wait_d == TIMEOUT_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            wait_q        <= '0;
            wdata_q       <= '0;
            address_q     <= '0;
            inst_q        <= '0;
            d_rdata_q     <= '0;
            num_inst_q    <= '0;
            readM_q       <= 1'b0;
            writeM_q      <= 1'b0;
            inst_valid_q  <= 1'b0;
            d_done_q      <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            // Completion pulses last exactly one cycle.
            inst_valid_q <= 1'b0;
            d_done_q     <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    // Address, strobe and state all change on the accept edge;
                    // request operands are latched so later input changes are
                    // invisible to the access in flight.
                    if (d_write) begin
                        state_q   <= DWRITE;
                        writeM_q  <= 1'b1;
                        address_q <= d_addr;
                        wdata_q   <= d_wdata;
                        wait_q    <= '0;
                        busy_q    <= 1'b1;
                    end else if (d_read) begin
                        state_q   <= DREAD;
                        readM_q   <= 1'b1;
                        address_q <= d_addr;
                        wait_q    <= '0;
                        busy_q    <= 1'b1;
                    end else if (fetch_req) begin
                        state_q   <= IFETCH;
                        readM_q   <= 1'b1;
                        address_q <= pc;
                        wait_q    <= '0;
                        busy_q    <= 1'b1;
                    end
                end

                IFETCH, DREAD: begin
                    // Only inputReady answers a read; ackOutput is ignored here.
                    if (inputReady) begin
                        readM_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                        if (state_q == IFETCH) begin
                            inst_q       <= data;
                            inst_valid_q <= 1'b1;
                            num_inst_q   <= num_inst_q + WORD_SIZE'(1);
                        end else begin
                            d_rdata_q <= data;
                            d_done_q  <= 1'b1;
                        end
                    end else if (timed_out) begin
                        readM_q       <= 1'b0;
                        timeout_err_q <= 1'b1;
                        wait_q        <= wait_d;
                        state_q       <= ERR;
                    end else begin
                        wait_q <= wait_d;
                    end
                end

                DWRITE: begin
                    // Only ackOutput completes a store; inputReady is ignored.
                    if (ackOutput) begin
                        writeM_q <= 1'b0;
                        busy_q   <= 1'b0;
                        d_done_q <= 1'b1;
                        state_q  <= IDLE;
                    end else if (timed_out) begin
                        writeM_q      <= 1'b0;
                        timeout_err_q <= 1'b1;
                        wait_q        <= wait_d;
                        state_q       <= ERR;
                    end else begin
                        wait_q <= wait_d;
                    end
                end

                ERR: begin
                    // Terminal: strobes stay low, busy stays high, only reset exits.
                end

                default: begin
                    state_q  <= ERR;
                    readM_q  <= 1'b0;
                    writeM_q <= 1'b0;
                    busy_q   <= 1'b1;
                end
            endcase
        end
    end

    // The bus is driven only by a store in progress; released on the ack edge.
    assign data = (state_q == DWRITE) ? wdata_q : {WORD_SIZE{1'bz}};

    assign inst        = inst_q;
    assign inst_valid  = inst_valid_q;
    assign d_rdata     = d_rdata_q;
    assign d_done      = d_done_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign num_inst    = num_inst_q;
    assign readM       = readM_q;
    assign writeM      = writeM_q;
    assign address     = address_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam logic [15:0] P = 16'h1234;  // bench probe value placed on an idle bus

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, d_read, d_write, inputReady, ackOutput;
    logic [15:0] pc, d_addr, d_wdata;
    logic        tb_oe;
    logic [15:0] tb_bus;
    wire  [15:0] data;
    logic [15:0] inst, d_rdata, num_inst, address;
    logic        inst_valid, d_done, busy, timeout_err, readM, writeM;

    // Memory side of the bus. When the bench drives the probe value and the
    // DUT is supposed to be released, any DUT drive corrupts what is read back.
    assign data = tb_oe ? tb_bus : 16'hzzzz;

    mem_access_ctrl #(.WORD_SIZE(16), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .pc(pc),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .inst(inst), .inst_valid(inst_valid), .d_rdata(d_rdata), .d_done(d_done),
        .busy(busy), .timeout_err(timeout_err), .num_inst(num_inst),
        .readM(readM), .writeM(writeM), .address(address), .data(data),
        .inputReady(inputReady), .ackOutput(ackOutput)
    );

    // Narrow instance so the fetch counter wrap is reachable in a few hundred
    // cycles: memory always ready, constant instruction word on the bus.
    logic       w_fetch;
    logic       w_oe;
    logic [7:0] w_zero;
    wire  [7:0] w_data;
    logic [7:0] w_inst, w_rdata, w_num, w_addr;
    logic       w_ival, w_ddone, w_busy, w_terr, w_rm, w_wm;
    assign w_data = w_oe ? 8'h5C : 8'hzz;

    mem_access_ctrl #(.WORD_SIZE(8), .TIMEOUT(8)) dut_wrap (
        .clk(clk), .reset(reset),
        .fetch_req(w_fetch), .pc(w_zero),
        .d_read(1'b0), .d_write(1'b0), .d_addr(w_zero), .d_wdata(w_zero),
        .inst(w_inst), .inst_valid(w_ival), .d_rdata(w_rdata), .d_done(w_ddone),
        .busy(w_busy), .timeout_err(w_terr), .num_inst(w_num),
        .readM(w_rm), .writeM(w_wm), .address(w_addr), .data(w_data),
        .inputReady(1'b1), .ackOutput(1'b0)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
        pc = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
        inputReady = 1'b0; ackOutput = 1'b0;
        tb_oe = 1'b1; tb_bus = P;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".readM"},       32'(readM),       32'd0);
        chk({tag, ".writeM"},      32'(writeM),      32'd0);
        chk({tag, ".address"},     32'(address),     32'd0);
        chk({tag, ".inst"},        32'(inst),        32'd0);
        chk({tag, ".d_rdata"},     32'(d_rdata),     32'd0);
        chk({tag, ".inst_valid"},  32'(inst_valid),  32'd0);
        chk({tag, ".d_done"},      32'(d_done),      32'd0);
        chk({tag, ".busy"},        32'(busy),        32'd0);
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, ".num_inst"},    32'(num_inst),    32'd0);
    endtask

    // One record = inputs held across one rising edge, outputs expected after it.
    typedef struct {
        logic        fr, dr, dw;
        logic [15:0] pc, da, wd;
        logic        ir, ack, oe;
        logic [15:0] bus;
        logic        e_rm, e_wm;
        logic [15:0] e_addr;
        logic        e_busy, e_iv, e_dd;
        logic [15:0] e_inst, e_rdata, e_num;
        logic        chk_d;
        logic [15:0] e_data;
    } vec_t;

    vec_t vq[$];

    initial begin
        int ival_cnt;

        // fetch 0010, answered with 6A05 after 3 waiting cycles; pc changes mid-access
        vq.push_back('{1,0,0, 16'h0010,16'h0000,16'h0000, 0,0,1,P,       1,0,16'h0010,1,0,0, 16'h0000,16'h0000,16'd0, 1,P});
        vq.push_back('{0,0,0, 16'hFFFF,16'h0000,16'h0000, 0,0,1,P,       1,0,16'h0010,1,0,0, 16'h0000,16'h0000,16'd0, 1,P});
        vq.push_back('{0,0,0, 16'hFFFF,16'h0000,16'h0000, 0,0,1,P,       1,0,16'h0010,1,0,0, 16'h0000,16'h0000,16'd0, 1,P});
        vq.push_back('{0,0,0, 16'hFFFF,16'h0000,16'h0000, 0,0,1,P,       1,0,16'h0010,1,0,0, 16'h0000,16'h0000,16'd0, 1,P});
        vq.push_back('{0,0,0, 16'hFFFF,16'h0000,16'h0000, 1,0,1,16'h6A05,0,0,16'h0010,0,1,0, 16'h6A05,16'h0000,16'd1, 1,16'h6A05});
        // inputReady while idle is ignored
        vq.push_back('{0,0,0, 16'h0000,16'h0000,16'h0000, 1,0,1,P,       0,0,16'h0010,0,0,0, 16'h6A05,16'h0000,16'd1, 1,P});
        // store BEEF to 0020, acked after 2 cycles; operands change and a stray inputReady arrives mid-access
        vq.push_back('{0,0,1, 16'h0000,16'h0020,16'hBEEF, 0,0,0,P,       0,1,16'h0020,1,0,0, 16'h6A05,16'h0000,16'd1, 1,16'hBEEF});
        vq.push_back('{0,0,0, 16'h0000,16'h0000,16'h0000, 1,0,0,P,       0,1,16'h0020,1,0,0, 16'h6A05,16'h0000,16'd1, 1,16'hBEEF});
        vq.push_back('{0,0,0, 16'h0000,16'h0000,16'h0000, 0,1,0,P,       0,0,16'h0020,0,0,1, 16'h6A05,16'h0000,16'd1, 0,16'h0000});
        vq.push_back('{0,0,0, 16'h0000,16'h0000,16'h0000, 0,1,1,P,       0,0,16'h0020,0,0,0, 16'h6A05,16'h0000,16'd1, 1,P});
        // fetch and load together: load first, fetch accepted on the edge after the d_done cycle begins
        vq.push_back('{1,1,0, 16'h0040,16'h0030,16'h0000, 0,0,1,P,       1,0,16'h0030,1,0,0, 16'h6A05,16'h0000,16'd1, 1,P});
        vq.push_back('{1,1,0, 16'h0040,16'h0030,16'h0000, 1,0,1,16'hC0DE,0,0,16'h0030,0,0,1, 16'h6A05,16'hC0DE,16'd1, 1,16'hC0DE});
        vq.push_back('{1,0,0, 16'h0040,16'h0030,16'h0000, 0,0,1,P,       1,0,16'h0040,1,0,0, 16'h6A05,16'hC0DE,16'd1, 1,P});
        // ackOutput during a fetch is the wrong response and is ignored
        vq.push_back('{0,0,0, 16'h0000,16'h0000,16'h0000, 0,1,1,P,       1,0,16'h0040,1,0,0, 16'h6A05,16'hC0DE,16'd1, 1,P});
        vq.push_back('{0,0,0, 16'h0000,16'h0000,16'h0000, 1,0,1,16'h1111,0,0,16'h0040,0,1,0, 16'h1111,16'hC0DE,16'd2, 1,16'h1111});
        vq.push_back('{0,0,0, 16'h0000,16'h0000,16'h0000, 0,0,1,P,       0,0,16'h0040,0,0,0, 16'h1111,16'hC0DE,16'd2, 1,P});
        // all three requests at once: store wins
        vq.push_back('{1,1,1, 16'h0060,16'h0050,16'hA5A5, 0,0,0,P,       0,1,16'h0050,1,0,0, 16'h1111,16'hC0DE,16'd2, 1,16'hA5A5});
        vq.push_back('{0,0,0, 16'h0000,16'h0000,16'h0000, 0,1,0,P,       0,0,16'h0050,0,0,1, 16'h1111,16'hC0DE,16'd2, 0,16'h0000});
        vq.push_back('{0,0,0, 16'h0000,16'h0000,16'h0000, 0,0,1,P,       0,0,16'h0050,0,0,0, 16'h1111,16'hC0DE,16'd2, 1,P});

        // ---- reset state ----
        idle_inputs();
        w_fetch = 1'b0; w_oe = 1'b1; w_zero = 8'h00;
        reset = 1'b1;
        tick(); tick();
        chk_reset_vals("rst");
        chk("rst.bus_released", 32'(data), 32'(P));
        reset = 1'b0;

        // ---- table-driven vectors ----
        for (int i = 0; i < vq.size(); i++) begin
            string t;
            t = $sformatf("v%0d", i);
            fetch_req = vq[i].fr; d_read = vq[i].dr; d_write = vq[i].dw;
            pc = vq[i].pc; d_addr = vq[i].da; d_wdata = vq[i].wd;
            inputReady = vq[i].ir; ackOutput = vq[i].ack;
            tb_oe = vq[i].oe; tb_bus = vq[i].bus;
            tick();
            chk({t, ".readM"},       32'(readM),       32'(vq[i].e_rm));
            chk({t, ".writeM"},      32'(writeM),      32'(vq[i].e_wm));
            chk({t, ".address"},     32'(address),     32'(vq[i].e_addr));
            chk({t, ".busy"},        32'(busy),        32'(vq[i].e_busy));
            chk({t, ".inst_valid"},  32'(inst_valid),  32'(vq[i].e_iv));
            chk({t, ".d_done"},      32'(d_done),      32'(vq[i].e_dd));
            chk({t, ".inst"},        32'(inst),        32'(vq[i].e_inst));
            chk({t, ".d_rdata"},     32'(d_rdata),     32'(vq[i].e_rdata));
            chk({t, ".num_inst"},    32'(num_inst),    32'(vq[i].e_num));
            chk({t, ".timeout_err"}, 32'(timeout_err), 32'd0);
            if (vq[i].chk_d)
                chk({t, ".data"}, 32'(data), 32'(vq[i].e_data));
            $display("%s rm=%b wm=%b addr=%h busy=%b iv=%b dd=%b inst=%h rdata=%h num=%0d data=%h",
                     t, readM, writeM, address, busy, inst_valid, d_done, inst, d_rdata, num_inst, data);
        end

        // ---- reset during a store with ack in the same cycle ----
        idle_inputs();
        d_write = 1'b1; d_addr = 16'h0070; d_wdata = 16'h7777; tb_oe = 1'b0;
        tick();
        chk("rmid.writeM", 32'(writeM), 32'd1);
        chk("rmid.data",   32'(data),   32'h7777);
        d_write = 1'b0; ackOutput = 1'b1; reset = 1'b1;
        tick();
        chk_reset_vals("rmid");
        reset = 1'b0; ackOutput = 1'b0; tb_oe = 1'b1; tb_bus = P;
        tick();
        chk("rmid.after_d_done", 32'(d_done), 32'd0);
        chk("rmid.after_busy",   32'(busy),   32'd0);
        chk("rmid.after_bus",    32'(data),   32'(P));
        $display("reset-mid-store wm=%b dd=%b busy=%b data=%h", writeM, d_done, busy, data);

        // ---- request asserted together with reset ----
        fetch_req = 1'b1; pc = 16'h0099; reset = 1'b1;
        tick();
        chk("rreq.readM",   32'(readM),   32'd0);
        chk("rreq.busy",    32'(busy),    32'd0);
        chk("rreq.address", 32'(address), 32'd0);
        reset = 1'b0; fetch_req = 1'b0;
        tick();
        chk("rreq.after_readM", 32'(readM), 32'd0);
        $display("request-with-reset rm=%b busy=%b addr=%h", readM, busy, address);

        // ---- timeout: fetch never answered, TIMEOUT=8 ----
        fetch_req = 1'b1; pc = 16'h0080;
        tick();
        chk("tmo.accept_readM", 32'(readM), 32'd1);
        fetch_req = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("tmo.wait%0d_readM", k), 32'(readM),       32'd1);
            chk($sformatf("tmo.wait%0d_err", k),   32'(timeout_err), 32'd0);
        end
        tick();
        chk("tmo.readM",  32'(readM),       32'd0);
        chk("tmo.err",    32'(timeout_err), 32'd1);
        chk("tmo.busy",   32'(busy),        32'd1);
        chk("tmo.writeM", 32'(writeM),      32'd0);
        inputReady = 1'b1; fetch_req = 1'b1; d_write = 1'b1; d_wdata = 16'hDEAD;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("err%0d.busy", k),   32'(busy),        32'd1);
            chk($sformatf("err%0d.readM", k),  32'(readM),       32'd0);
            chk($sformatf("err%0d.writeM", k), 32'(writeM),      32'd0);
            chk($sformatf("err%0d.err", k),    32'(timeout_err), 32'd1);
            chk($sformatf("err%0d.bus", k),    32'(data),        32'(P));
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        chk("tmo.rst_err",  32'(timeout_err), 32'd0);
        chk("tmo.rst_busy", 32'(busy),        32'd0);
        reset = 1'b0;
        $display("timeout err=%b busy=%b after reset", timeout_err, busy);

        // ---- fetch counter wrap on the 8-bit instance ----
        w_fetch = 1'b1;
        ival_cnt = 0;
        for (int k = 1; k <= 512; k++) begin
            tick();
            if (w_ival) ival_cnt++;
            if (k == 510) chk("wrap.num_ff", 32'(w_num), 32'hFF);
        end
        chk("wrap.num_zero", 32'(w_num),   32'h00);
        chk("wrap.ival",     32'(w_ival),  32'd1);
        chk("wrap.pulses",   32'(ival_cnt), 32'd256);
        chk("wrap.inst",     32'(w_inst),  32'h5C);
        chk("wrap.err",      32'(w_terr),  32'd0);
        chk("wrap.wm",       32'(w_wm),    32'd0);
        chk("wrap.ddone",    32'(w_ddone), 32'd0);
        chk("wrap.rdata",    32'(w_rdata), 32'h00);
        $display("wrap num=%h pulses=%0d inst=%h busy=%b rm=%b addr=%h",
                 w_num, ival_cnt, w_inst, w_busy, w_rm, w_addr);
        w_fetch = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
